// File: rtl/gate_vec_pkg.sv
// Shared types and constants for the gate vector sequencer.
package gate_vec_pkg;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int ERR_W       = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

  // Increment an error count, sticking at ERR_MAX instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v == ERR_MAX) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gate_vector_sequencer_hold_timer.sv
// Loadable 8-bit down-counter that paces how long each vector is held.
module hold_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_load,
  input  logic [7:0] i_value,
  input  logic       i_en,
  output logic       o_expire
);

  logic [7:0] r_count;

  // Load has priority; otherwise count down while enabled, stopping at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_en && (r_count != 8'd0)) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_expire = (r_count == 8'd0);

endmodule

// File: rtl/gate_vector_sequencer.sv
// Drives a two-input gate through all input patterns, samples its output on
// the last cycle of each pattern and checks it against a truth table.
module gate_vector_sequencer
  import gate_vec_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 5,
  parameter int unsigned PASSES      = 1,
  parameter logic [3:0]  EXPECT_TT   = 4'b1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             out,
  output logic             in0,
  output logic             in1,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       first_fail_vec,
  output logic             fail_seen
);

  // Reject out-of-range parameters at elaboration.
  generate
    if ((HOLD_CYCLES < 2) || (HOLD_CYCLES > 255)) begin : g_bad_hold
      $error("gate_vector_sequencer: HOLD_CYCLES must be 2..255");
    end
    if ((PASSES < 1) || (PASSES > 63)) begin : g_bad_passes
      $error("gate_vector_sequencer: PASSES must be 1..63");
    end
  endgenerate

  // The HOLD phase covers HOLD_CYCLES-1 cycles (count N-2 down to 0) and the
  // SAMPLE cycle adds one more, giving exactly HOLD_CYCLES per vector.
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 2);
  localparam logic [5:0] LAST_PASS = 6'(PASSES - 1);
  localparam logic [1:0] LAST_VEC  = 2'(NUM_VECTORS - 1);

  state_t           r_state;
  logic [1:0]       r_vec;
  logic [5:0]       r_pass_cnt;
  logic [ERR_W-1:0] r_err_count;
  logic [1:0]       r_first_fail_vec;
  logic             r_fail_seen;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;

  logic             w_start_ok;
  logic             w_mismatch;
  logic             w_finish;
  logic [ERR_W-1:0] w_err_next;
  logic             w_timer_load;
  logic             w_timer_en;
  logic             w_expire;

  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_mismatch   = (out != EXPECT_TT[r_vec]);
  assign w_finish     = (r_vec == LAST_VEC) && (r_pass_cnt == LAST_PASS);
  assign w_err_next   = w_mismatch ? sat_inc(r_err_count) : r_err_count;
  assign w_timer_load = w_start_ok || ((r_state == SAMPLE) && !w_finish);
  assign w_timer_en   = (r_state == HOLD);

  hold_timer u_hold_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_timer_load),
    .i_value  (HOLD_LOAD),
    .i_en     (w_timer_en),
    .o_expire (w_expire)
  );

  // Sequencer FSM: vector/pass stepping, checking and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_vec            <= 2'b00;
      r_pass_cnt       <= '0;
      r_err_count      <= '0;
      r_first_fail_vec <= 2'b00;
      r_fail_seen      <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state          <= HOLD;
            r_vec            <= 2'b00;
            r_pass_cnt       <= '0;
            r_err_count      <= '0;
            r_first_fail_vec <= 2'b00;
            r_fail_seen      <= 1'b0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
          end
        end
        HOLD: begin
          if (w_expire) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_err_count <= w_err_next;
          if (w_mismatch && !r_fail_seen) begin
            r_first_fail_vec <= r_vec;
            r_fail_seen      <= 1'b1;
          end
          if (w_finish) begin
            // Last vector of the last pass: publish results; the final
            // vector stays on the gate inputs.
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec   <= r_vec + 2'b01;
            r_state <= HOLD;
            if (r_vec == LAST_VEC) begin
              r_pass_cnt <= r_pass_cnt + 6'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in0            = r_vec[1];
  assign in1            = r_vec[0];
  assign busy           = r_busy;
  assign done           = r_done;
  assign pass           = r_pass;
  assign err_count      = r_err_count;
  assign first_fail_vec = r_first_fail_vec;
  assign fail_seen      = r_fail_seen;

endmodule

// File: tb/tb_gate_vector_sequencer.sv
// Testbench: four sequencer instances with different parameters, each driving
// a bench-side gate whose truth table is chosen per run.
module tb_gate_vector_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] start_v = '0;
  logic [3:0] out_v;
  logic [3:0] in0_v, in1_v, busy_v, done_v, pass_v, fs_v;
  logic [7:0] err_v [4];
  logic [1:0] ffv_v [4];
  logic [3:0] gt_v  [4];

  int         hold_of   [4] = '{5, 5, 2, 3};
  int         passes_of [4] = '{1, 3, 1, 2};
  logic [3:0] expect_of [4] = '{4'b1000, 4'b1000, 4'b1110, 4'b0110};

  int n_tests = 0;
  int n_fail  = 0;

  // Gates under test: combinational lookup into a per-instance truth table.
  for (genvar gi = 0; gi < 4; gi++) begin : g_gate
    assign out_v[gi] = gt_v[gi][{in0_v[gi], in1_v[gi]}];
  end

  gate_vector_sequencer u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .out(out_v[0]),
    .in0(in0_v[0]), .in1(in1_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .first_fail_vec(ffv_v[0]),
    .fail_seen(fs_v[0]));

  gate_vector_sequencer #(.PASSES(3)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .out(out_v[1]),
    .in0(in0_v[1]), .in1(in1_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .first_fail_vec(ffv_v[1]),
    .fail_seen(fs_v[1]));

  gate_vector_sequencer #(.HOLD_CYCLES(2), .EXPECT_TT(4'b1110)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .out(out_v[2]),
    .in0(in0_v[2]), .in1(in1_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .first_fail_vec(ffv_v[2]),
    .fail_seen(fs_v[2]));

  gate_vector_sequencer #(.HOLD_CYCLES(3), .PASSES(2), .EXPECT_TT(4'b0110)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .out(out_v[3]),
    .in0(in0_v[3]), .in1(in1_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .pass(pass_v[3]), .err_count(err_v[3]), .first_fail_vec(ffv_v[3]),
    .fail_seen(fs_v[3]));

  typedef struct {
    int         d;
    logic [3:0] gate;
    int         exp_err;
    logic [1:0] exp_ffv;
    logic       exp_fs;
    logic       exp_pass;
    int         exp_cycles;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s dut=%0d got=%0h want=%0h", name, d, act, exp);
    end
  endtask

  // Reference model: every vector is checked once per pass, so each truth
  // table bit that disagrees costs PASSES errors; the first failure is the
  // lowest disagreeing vector in sweep order.
  function automatic int model_err(input logic [3:0] g, input logic [3:0] e, input int p);
    int n = 0;
    for (int v = 0; v < 4; v++) if (g[v] != e[v]) n += p;
    return (n > 255) ? 255 : n;
  endfunction

  function automatic logic [1:0] model_ffv(input logic [3:0] g, input logic [3:0] e);
    for (int v = 0; v < 4; v++) if (g[v] != e[v]) return 2'(v);
    return 2'b00;
  endfunction

  // Start a run on instance d and follow it to done, checking the vector
  // sequence; optionally pulse start again at offset poke_k while busy.
  task automatic run_dut(input int d, input int poke_k, output int cycles);
    int h, p, len, k, bad_k;
    logic [1:0] exp_vec, bad_got;
    bit seq_ok;
    h = hold_of[d];
    p = passes_of[d];
    len = 4 * h * p;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(negedge clk);
    start_v[d] = 1'b0;
    check("start_clear", d, 32'({done_v[d], busy_v[d], err_v[d], fs_v[d], pass_v[d]}),
          32'({1'b0, 1'b1, 8'd0, 1'b0, 1'b0}));
    k = 0;
    seq_ok = 1'b1;
    bad_k = -1;
    bad_got = 2'b00;
    while (!done_v[d] && (k < len + 10)) begin
      exp_vec = 2'((k / h) % 4);
      if ((k < len) && seq_ok && (({in0_v[d], in1_v[d]} != exp_vec) || !busy_v[d])) begin
        seq_ok = 1'b0;
        bad_k = k;
        bad_got = {in0_v[d], in1_v[d]};
      end
      start_v[d] = (k == poke_k);
      k++;
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    cycles = k;
    if (!seq_ok)
      $display("[TB] FAIL vec_seq detail dut=%0d cycle=%0d got=%0b", d, bad_k, bad_got);
    check("vec_seq", d, 32'(seq_ok), 32'd1);
    check("run_len", d, 32'(cycles), 32'(len));
    check("busy_low_at_done", d, 32'({busy_v[d], done_v[d]}), 32'(2'b01));
  endtask

  task automatic check_results(input int d, input int e_err, input logic [1:0] e_ffv,
                               input logic e_fs, input logic e_pass);
    check("err_count", d, 32'(err_v[d]), 32'(e_err));
    check("first_fail_vec", d, 32'(ffv_v[d]), 32'(e_ffv));
    check("fail_seen", d, 32'(fs_v[d]), 32'(e_fs));
    check("pass", d, 32'(pass_v[d]), 32'(e_pass));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, d, poke;
    logic [3:0] g;

    for (int i = 0; i < 4; i++) gt_v[i] = 4'b1000;

    // Hand-computed expectations: {dut, gate, err, ffv, fail_seen, pass, cycles}
    tbl[0] = '{0, 4'b0000, 1, 2'b11, 1'b1, 1'b0, 20};  // stuck-at-0
    tbl[1] = '{0, 4'b1000, 0, 2'b00, 1'b0, 1'b1, 20};  // correct AND, start from DONE
    tbl[2] = '{0, 4'b1111, 3, 2'b00, 1'b1, 1'b0, 20};  // stuck-at-1
    tbl[3] = '{0, 4'b1110, 2, 2'b01, 1'b1, 1'b0, 20};  // OR attached
    tbl[4] = '{0, 4'b0110, 3, 2'b01, 1'b1, 1'b0, 20};  // XOR attached
    tbl[5] = '{0, 4'b0111, 4, 2'b00, 1'b1, 1'b0, 20};  // NAND attached
    tbl[6] = '{1, 4'b1111, 9, 2'b00, 1'b1, 1'b0, 60};  // stuck-at-1, 3 passes
    tbl[7] = '{2, 4'b1000, 2, 2'b01, 1'b1, 1'b0, 8};   // AND vs OR table, hold 2

    // Reset state on every instance
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check("reset_state", i, 32'({in0_v[i], in1_v[i], busy_v[i], done_v[i], pass_v[i],
                                   err_v[i], ffv_v[i], fs_v[i]}), 32'd0);
    rst = 1'b0;

    // Table-driven directed runs
    for (int t = 0; t < 8; t++) begin
      gt_v[tbl[t].d] = tbl[t].gate;
      run_dut(tbl[t].d, -1, cyc);
      check("tbl_cycles", tbl[t].d, 32'(cyc), 32'(tbl[t].exp_cycles));
      check_results(tbl[t].d, tbl[t].exp_err, tbl[t].exp_ffv, tbl[t].exp_fs, tbl[t].exp_pass);
    end

    // start pulsed while busy must not restart or lengthen the run
    gt_v[0] = 4'b0000;
    run_dut(0, 7, cyc);
    check("busy_start_ignored_len", 0, 32'(cyc), 32'd20);
    check_results(0, 1, 2'b11, 1'b1, 1'b0);

    // Reset in the middle of a run, then a clean run
    gt_v[0] = 4'b1111;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrun_reset", 0, 32'({in0_v[0], in1_v[0], busy_v[0], done_v[0], pass_v[0],
                                  err_v[0], ffv_v[0], fs_v[0]}), 32'd0);
    rst = 1'b0;
    gt_v[0] = 4'b1000;
    run_dut(0, -1, cyc);
    check_results(0, 0, 2'b00, 1'b0, 1'b1);

    // Randomized gates against the reference model
    for (int r = 0; r < 16; r++) begin
      d = ($urandom_range(0, 1) == 0) ? 0 : 3;
      g = 4'($urandom);
      gt_v[d] = g;
      poke = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4 * hold_of[d] * passes_of[d] - 2) : -1;
      run_dut(d, poke, cyc);
      check_results(d, model_err(g, expect_of[d], passes_of[d]), model_ffv(g, expect_of[d]),
                    (g != expect_of[d]), (g == expect_of[d]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
